// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch front end. It sits directly in front of the instruction
// memory and does the following:
//   - owns the PC and drives the fetch byte address;
//   - picks the next PC (sequential, branch, jump or jump-register);
//   - holds the PC on decode stalls and squashes wrong-path words;
//   - stops fetch when a correct-path halt word comes back;
//   - gates the downstream pipeline in single-step debug mode;
//   - counts enabled cycles for the debug unit.
//
// The memory read is registered, so i_Instruction in any cycle is the word
// at the o_PC of the cycle before.
//
// Ports:
//   i_clk, i_reset       clock; synchronous active-high reset
//   i_Start, i_StepMode  leave IDLE; select continuous (0) or single-step (1)
//   i_Step               one-cycle pulse that enables one cycle in STEP
//   i_Stall              decode hazard stall (hold PC, mask redirects)
//   i_Branch/Target      taken branch and its byte address
//   i_Jump/JumpIndex     J-type jump and its 26-bit instr_index
//   i_JumpR/JumpRTarget  jump-register and its target
//   i_Instruction        word returned by instruction memory
//   o_PC, o_PC_4         fetch address and fetch address + 4
//   o_InstrValid         i_Instruction is a correct-path word
//   o_Flush              squash IF/ID this cycle
//   o_PipeEnable         clock enable for downstream pipeline registers
//   o_Halted, o_Running  state is HALT / state is RUN or STEP
//   o_CycleCount         number of enabled cycles
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int               NBITS     = 32,
  parameter logic [NBITS-1:0] RESET_PC  = 32'd4,
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Start,
  input  logic             i_StepMode,
  input  logic             i_Step,
  input  logic             i_Stall,
  input  logic             i_Branch,
  input  logic [NBITS-1:0] i_BranchTarget,
  input  logic             i_Jump,
  input  logic [25:0]      i_JumpIndex,
  input  logic             i_JumpR,
  input  logic [NBITS-1:0] i_JumpRTarget,
  input  logic [NBITS-1:0] i_Instruction,
  output logic [NBITS-1:0] o_PC,
  output logic [NBITS-1:0] o_PC_4,
  output logic             o_InstrValid,
  output logic             o_Flush,
  output logic             o_PipeEnable,
  output logic             o_Halted,
  output logic             o_Running,
  output logic [31:0]      o_CycleCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [NBITS-1:0] pc;
  logic [NBITS-1:0] pc_next;
  logic [NBITS-1:0] pc_plus4;
  logic [NBITS-1:0] jump_target;
  logic             fetch_q;
  logic             fetch_next;
  logic [31:0]      cycle_count;
  logic             active;
  logic             redirect;
  logic             instr_valid;
  logic             halt_hit;

  // Arithmetic wraps modulo 2^NBITS. The jump target keeps the top nibble
  // of the current PC, as a J-type jump does.
  assign pc_plus4    = pc + NBITS'(4);
  assign jump_target = NBITS'({pc[NBITS-1 -: 4], i_JumpIndex, 2'b00});

  always_comb begin
    active      = 1'b0;
    redirect    = 1'b0;
    instr_valid = 1'b0;
    halt_hit    = 1'b0;
    state_next  = state;
    pc_next     = pc;
    fetch_next  = fetch_q;

    active   = (state == RUN) | ((state == STEP) & i_Step);
    // A stall masks a redirect. Decode re-asserts the redirect once the
    // stall drops.
    redirect = active & ~i_Stall & (i_Jump | i_JumpR | i_Branch);
    // The word in flight is wrong-path if it was fetched behind a redirect
    // (fetch_q = 0), or if a redirect is being taken this cycle.
    instr_valid = fetch_q & ~redirect;
    // A squashed or stalled halt word never halts.
    halt_hit = active & instr_valid & ~i_Stall & (i_Instruction == HALT_WORD);

    unique case (state)
      IDLE: begin
        if (i_Start) begin
          state_next = i_StepMode ? STEP : RUN;
        end
      end
      RUN, STEP: begin
        if (halt_hit) begin
          state_next = HALT;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The PC freezes on the halting cycle so that it points just past the
    // halt word. The halt word itself still enters IF/ID.
    if (active && !i_Stall && !halt_hit) begin
      if (i_JumpR) begin
        pc_next = i_JumpRTarget;
      end else if (i_Jump) begin
        pc_next = jump_target;
      end else if (i_Branch) begin
        pc_next = i_BranchTarget;
      end else begin
        pc_next = pc_plus4;
      end
    end

    // The word fetched this cycle is known to be wrong-path if a redirect
    // is taken now. It is also discarded if fetch is about to stop.
    if (active) begin
      fetch_next = ~redirect & (state_next != HALT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      fetch_q     <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      fetch_q <= fetch_next;
      if (active) begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

  assign o_PC         = pc;
  assign o_PC_4       = pc_plus4;
  assign o_InstrValid = instr_valid;
  assign o_Flush      = redirect;
  assign o_PipeEnable = active;
  assign o_Halted     = (state == HALT);
  assign o_Running    = (state == RUN) | (state == STEP);
  assign o_CycleCount = cycle_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed-vector bench for pc_fetch_unit.
//
// The stimulus process works one clock cycle at a time. For each cycle it
// drives the control inputs and queues the outputs expected during that
// cycle. These expected values are computed by hand. A monitor on the
// falling edge pops the queue and compares. A small registered memory model
// supplies i_Instruction. The model places halt words inside a
// programmable address window.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  typedef struct packed {
    logic        reset;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        stall;
    logic        branch;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_r;
    logic [31:0] jump_r_target;
  } stim_t;

  typedef struct packed {
    logic        chk;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        pipe;
    logic        halted;
    logic        running;
    logic [31:0] count;
  } exp_t;

  logic        i_clk;
  logic        i_reset;
  logic        i_Start;
  logic        i_StepMode;
  logic        i_Step;
  logic        i_Stall;
  logic        i_Branch;
  logic [31:0] i_BranchTarget;
  logic        i_Jump;
  logic [25:0] i_JumpIndex;
  logic        i_JumpR;
  logic [31:0] i_JumpRTarget;
  logic [31:0] i_Instruction = 32'd0;
  logic [31:0] o_PC;
  logic [31:0] o_PC_4;
  logic        o_InstrValid;
  logic        o_Flush;
  logic        o_PipeEnable;
  logic        o_Halted;
  logic        o_Running;
  logic [31:0] o_CycleCount;

  logic [31:0] halt_lo;
  logic [31:0] halt_hi;
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  pc_fetch_unit dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_Start        (i_Start),
    .i_StepMode     (i_StepMode),
    .i_Step         (i_Step),
    .i_Stall        (i_Stall),
    .i_Branch       (i_Branch),
    .i_BranchTarget (i_BranchTarget),
    .i_Jump         (i_Jump),
    .i_JumpIndex    (i_JumpIndex),
    .i_JumpR        (i_JumpR),
    .i_JumpRTarget  (i_JumpRTarget),
    .i_Instruction  (i_Instruction),
    .o_PC           (o_PC),
    .o_PC_4         (o_PC_4),
    .o_InstrValid   (o_InstrValid),
    .o_Flush        (o_Flush),
    .o_PipeEnable   (o_PipeEnable),
    .o_Halted       (o_Halted),
    .o_Running      (o_Running),
    .o_CycleCount   (o_CycleCount)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Registered-read instruction memory. A normal word always has its low
  // bits set to 01, so it can never equal the halt word.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a >= halt_lo && a <= halt_hi) return 32'hFFFFFFFF;
    return {a[31:2], 2'b01};
  endfunction

  always @(posedge i_clk) begin
    i_Instruction <= memWord(o_PC);
  end

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic exp_t ex(input logic [31:0] pc, input logic valid,
                              input logic flush, input logic pipe,
                              input logic halted, input logic running,
                              input logic [31:0] count);
    exp_t e;
    e.chk     = 1'b1;
    e.pc      = pc;
    e.valid   = valid;
    e.flush   = flush;
    e.pipe    = pipe;
    e.halted  = halted;
    e.running = running;
    e.count   = count;
    return e;
  endfunction

  function automatic exp_t skip();
    exp_t e;
    e = '0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Drives one cycle's inputs, queues the outputs expected before the next
  // rising edge, then waits past that edge.
  task automatic applyStimulus(input stim_t s, input exp_t e);
    i_reset        = s.reset;
    i_Start        = s.start;
    i_StepMode     = s.step_mode;
    i_Step         = s.step;
    i_Stall        = s.stall;
    i_Branch       = s.branch;
    i_BranchTarget = s.branch_target;
    i_Jump         = s.jump;
    i_JumpIndex    = s.jump_index;
    i_JumpR        = s.jump_r;
    i_JumpRTarget  = s.jump_r_target;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        checkOutput("pc",      o_PC,                 e.pc);
        checkOutput("pc_4",    o_PC_4,               e.pc + 32'd4);
        checkOutput("valid",   {31'd0, o_InstrValid}, {31'd0, e.valid});
        checkOutput("flush",   {31'd0, o_Flush},      {31'd0, e.flush});
        checkOutput("pipe_en", {31'd0, o_PipeEnable}, {31'd0, e.pipe});
        checkOutput("halted",  {31'd0, o_Halted},     {31'd0, e.halted});
        checkOutput("running", {31'd0, o_Running},    {31'd0, e.running});
        checkOutput("count",   o_CycleCount,          e.count);
      end
    end
  end

  initial begin
    stim_t s;
    halt_lo        = 32'd108;
    halt_hi        = 32'd108;
    i_reset        = 1'b1;
    i_Start        = 1'b0;
    i_StepMode     = 1'b0;
    i_Step         = 1'b0;
    i_Stall        = 1'b0;
    i_Branch       = 1'b0;
    i_BranchTarget = 32'd0;
    i_Jump         = 1'b0;
    i_JumpIndex    = 26'd0;
    i_JumpR        = 1'b0;
    i_JumpRTarget  = 32'd0;
    @(posedge i_clk);
    #1;

    $display("[TB] reset and continuous run");
    s = nop(); s.reset = 1'b1;
    applyStimulus(s, skip());
    applyStimulus(nop(), ex(32'd4, 0, 0, 0, 0, 0, 32'd0));
    s = nop(); s.start = 1'b1;
    applyStimulus(s, ex(32'd4, 0, 0, 0, 0, 0, 32'd0));
    applyStimulus(nop(), ex(32'd4, 0, 0, 1, 0, 1, 32'd0));
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(nop(), ex(32'd4 + 32'(4 * k), 1, 0, 1, 0, 1, 32'(k)));
    end

    $display("[TB] branch, jump, jump-register, stalled branch");
    s = nop(); s.branch = 1'b1; s.branch_target = 32'd60;
    applyStimulus(s, ex(32'd32, 0, 1, 1, 0, 1, 32'd7));
    applyStimulus(nop(), ex(32'd60, 0, 0, 1, 0, 1, 32'd8));
    applyStimulus(nop(), ex(32'd64, 1, 0, 1, 0, 1, 32'd9));
    s = nop(); s.jump = 1'b1; s.jump_index = 26'd5;
    applyStimulus(s, ex(32'd68, 0, 1, 1, 0, 1, 32'd10));
    s.jump_r = 1'b1; s.jump_r_target = 32'd100;
    applyStimulus(s, ex(32'd20, 0, 1, 1, 0, 1, 32'd11));
    applyStimulus(nop(), ex(32'd100, 0, 0, 1, 0, 1, 32'd12));
    s = nop(); s.stall = 1'b1; s.branch = 1'b1; s.branch_target = 32'd200;
    applyStimulus(s, ex(32'd104, 1, 0, 1, 0, 1, 32'd13));
    applyStimulus(nop(), ex(32'd104, 1, 0, 1, 0, 1, 32'd14));
    applyStimulus(nop(), ex(32'd108, 1, 0, 1, 0, 1, 32'd15));

    $display("[TB] squashed halt word, stalled halt word, real halt");
    s = nop(); s.branch = 1'b1; s.branch_target = 32'd200;
    applyStimulus(s, ex(32'd112, 0, 1, 1, 0, 1, 32'd16));
    halt_lo = 32'd208;
    halt_hi = 32'd212;
    applyStimulus(nop(), ex(32'd200, 0, 0, 1, 0, 1, 32'd17));
    applyStimulus(nop(), ex(32'd204, 1, 0, 1, 0, 1, 32'd18));
    applyStimulus(nop(), ex(32'd208, 1, 0, 1, 0, 1, 32'd19));
    s = nop(); s.stall = 1'b1;
    applyStimulus(s, ex(32'd212, 1, 0, 1, 0, 1, 32'd20));
    applyStimulus(nop(), ex(32'd212, 1, 0, 1, 0, 1, 32'd21));
    applyStimulus(nop(), ex(32'd212, 0, 0, 0, 1, 0, 32'd22));
    s = nop(); s.start = 1'b1; s.branch = 1'b1; s.branch_target = 32'd60;
    applyStimulus(s, ex(32'd212, 0, 0, 0, 1, 0, 32'd22));
    halt_lo = 32'd1;
    halt_hi = 32'd0;

    $display("[TB] reset from HALT, single-step mode");
    s = nop(); s.reset = 1'b1;
    applyStimulus(s, skip());
    applyStimulus(nop(), ex(32'd4, 0, 0, 0, 0, 0, 32'd0));
    s = nop(); s.start = 1'b1; s.step_mode = 1'b1;
    applyStimulus(s, ex(32'd4, 0, 0, 0, 0, 0, 32'd0));
    applyStimulus(nop(), ex(32'd4, 0, 0, 0, 0, 1, 32'd0));
    for (int p = 0; p < 3; p++) begin
      s = nop(); s.step = 1'b1;
      applyStimulus(s, ex(32'd4 + 32'(4 * p), (p > 0), 0, 1, 0, 1, 32'(p)));
      for (int w = 0; w < 4; w++) begin
        applyStimulus(nop(), ex(32'd8 + 32'(4 * p), 1, 0, 0, 0, 1, 32'(p + 1)));
      end
    end
    s = nop(); s.step = 1'b1; s.stall = 1'b1;
    applyStimulus(s, ex(32'd16, 1, 0, 1, 0, 1, 32'd3));
    applyStimulus(nop(), ex(32'd16, 1, 0, 0, 0, 1, 32'd4));

    $display("[TB] reset while running");
    s = nop(); s.reset = 1'b1;
    applyStimulus(s, skip());
    applyStimulus(nop(), ex(32'd4, 0, 0, 0, 0, 0, 32'd0));
    s = nop(); s.start = 1'b1;
    applyStimulus(s, ex(32'd4, 0, 0, 0, 0, 0, 32'd0));
    applyStimulus(nop(), ex(32'd4, 0, 0, 1, 0, 1, 32'd0));
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(nop(), ex(32'd4 + 32'(4 * k), 1, 0, 1, 0, 1, 32'(k)));
    end
    s = nop(); s.reset = 1'b1;
    applyStimulus(s, skip());
    applyStimulus(nop(), ex(32'd4, 0, 0, 0, 0, 0, 32'd0));

    $display("[TB] PC wrap at top of address space");
    s = nop(); s.start = 1'b1;
    applyStimulus(s, ex(32'd4, 0, 0, 0, 0, 0, 32'd0));
    s = nop(); s.jump_r = 1'b1; s.jump_r_target = 32'hFFFFFFFC;
    applyStimulus(s, ex(32'd4, 0, 1, 1, 0, 1, 32'd0));
    applyStimulus(nop(), ex(32'hFFFFFFFC, 0, 0, 1, 0, 1, 32'd1));
    applyStimulus(nop(), ex(32'd0, 1, 0, 1, 0, 1, 32'd2));

    repeat (3) @(posedge i_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
